// File: rtl/ram_banked_pkg.sv
// Shared types and helpers for the banked RAM controller.
// Optional build macro: RAM_INIT_CLEAR_EN (zero-fill all banks after reset).
package ram_banked_pkg;

   localparam int unsigned BYTE_W = 8;

   // Init-clear sequencer states (used only when RAM_INIT_CLEAR_EN is defined).
   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Low-order interleave: bank index is the low log2(num_banks) address bits.
   function automatic int unsigned addr_bank(input logic [31:0] addr,
                                             input int unsigned num_banks);
      int unsigned bb;
      bb = int'($clog2(num_banks));
      return int'(addr & ((32'd1 << bb) - 32'd1));
   endfunction

   // Row is whatever remains above the bank bits.
   function automatic int unsigned addr_row(input logic [31:0] addr,
                                            input int unsigned num_banks);
      int unsigned bb;
      bb = int'($clog2(num_banks));
      return int'(addr >> bb);
   endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: DEPTH words with per-byte write enables and a registered read port.
// The read register only loads on an enabled read, so write-only accesses and
// idle cycles leave the last read word visible.
module ram_bank
   import ram_banked_pkg::*;
#(
   parameter int unsigned WSIZE = 4,
   parameter int unsigned DEPTH = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic [WSIZE-1:0]            we_i,
   input  logic [$clog2(DEPTH)-1:0]    addr_i,
   input  logic [WSIZE*BYTE_W-1:0]     wdata_i,
   output logic [WSIZE*BYTE_W-1:0]     rdata_o
);

   localparam int unsigned DW = WSIZE * BYTE_W;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Byte-lane write into storage; contents are never reset.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int i = 0; i < int'(WSIZE); i++) begin
            if (we_i[i]) begin
               mem_q[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Read register: loads only on an enabled access with no byte lanes set.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (en_i && (we_i == '0)) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_banked_ctrl.sv
// Banked, handshaked RAM controller between the load/store unit and on-chip SRAM.
// NUM_BANKS low-order-interleaved banks, 1-cycle read latency, response
// backpressure that stalls the request port combinationally.
// Optional build macro: RAM_INIT_CLEAR_EN -- after reset, every row of every bank
// is written with zero (one row per cycle) before requests are accepted.
module ram_banked_ctrl
   import ram_banked_pkg::*;
#(
   parameter int unsigned WSIZE     = 4,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned NUM_BANKS = 2
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic [WSIZE-1:0]                    req_we,
   input  logic [$clog2(DEPTH*NUM_BANKS)-1:0]  req_addr,
   input  logic [WSIZE*BYTE_W-1:0]             req_wdata,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic [WSIZE*BYTE_W-1:0]             rsp_rdata,
   output logic [NUM_BANKS-1:0]                bank_en
);

   localparam int unsigned AW = $clog2(DEPTH * NUM_BANKS);
   localparam int unsigned DW = WSIZE * BYTE_W;
   localparam int unsigned RW = $clog2(DEPTH);
   localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [BW-1:0]    req_bank;
   logic [RW-1:0]    req_row;
   logic             stall;
   logic             init_busy;
   logic             init_active;
   logic             accept;
   logic             rd_accept;
   logic [RW-1:0]    init_row;

   logic             rsp_valid_q, rsp_valid_d;
   logic [BW-1:0]    bank_sel_q, bank_sel_d;

   logic [WSIZE-1:0] bank_we;
   logic [RW-1:0]    bank_addr;
   logic [DW-1:0]    bank_wdata;
   logic [DW-1:0]    bank_rdata [NUM_BANKS];

   // Split the word address into bank index and row.
   always_comb begin
      req_bank = BW'(addr_bank(32'(req_addr), NUM_BANKS));
      req_row  = RW'(addr_row(32'(req_addr), NUM_BANKS));
   end

   // Handshake: a held response blocks new requests (rsp_ready -> req_ready path).
   always_comb begin
      stall       = rsp_valid_q && !rsp_ready;
      req_ready   = !RST && !stall && !init_busy;
      accept      = req_valid && req_ready;
      rd_accept   = accept && (req_we == '0);
      init_active = init_busy && !RST;
   end

`ifdef RAM_INIT_CLEAR_EN
   state_e        state_q, state_d;
   logic [RW-1:0] init_row_q, init_row_d;

   // Init sequencer next state: walk rows 0..DEPTH-1, then hand over to RUN.
   always_comb begin
      state_d    = state_q;
      init_row_d = init_row_q;
      if (state_q == INIT) begin
         init_row_d = init_row_q + 1'b1;
         if (init_row_q == RW'(DEPTH - 1)) begin
            state_d = RUN;
         end
      end
   end

   // Init sequencer state; any reset restarts the clear from row 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= INIT;
         init_row_q <= '0;
      end else begin
         state_q    <= state_d;
         init_row_q <= init_row_d;
      end
   end

   assign init_busy = (state_q == INIT);
   assign init_row  = init_row_q;
`else
   assign init_busy = 1'b0;
   assign init_row  = '0;
`endif

   // Bank port steering: init clear hits all banks, otherwise only the accepted bank.
   always_comb begin
      bank_en    = '0;
      bank_we    = req_we;
      bank_addr  = req_row;
      bank_wdata = req_wdata;
      if (init_active) begin
         bank_en    = '1;
         bank_we    = '1;
         bank_addr  = init_row;
         bank_wdata = '0;
      end else if (accept) begin
         bank_en[req_bank] = 1'b1;
      end
   end

   // Response next state: a new read refills, a consumed response drains.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      bank_sel_d  = bank_sel_q;
      if (rd_accept) begin
         rsp_valid_d = 1'b1;
         bank_sel_d  = req_bank;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Response state registers; reset drops any pending response.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp_valid_q <= 1'b0;
         bank_sel_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         bank_sel_q  <= bank_sel_d;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      ram_bank #(
         .WSIZE (WSIZE),
         .DEPTH (DEPTH)
      ) u_bank (
         .clk_i   (CLK),
         .rst_i   (RST),
         .en_i    (bank_en[b]),
         .we_i    (bank_we),
         .addr_i  (bank_addr),
         .wdata_i (bank_wdata),
         .rdata_o (bank_rdata[b])
      );
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = bank_rdata[bank_sel_q];

endmodule
